// File: rtl/ioctl_loader_bridge_if.sv
// rtl/ioctl_loader_bridge_if.sv - hps_io download stream and core loader port bundle
interface ioctl_loader_bridge_if #(
    parameter int BYTES  = 2,
    parameter int ADDR_W = 20,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                ioctl_download;
    logic [7:0]          ioctl_index;
    logic                ioctl_wr;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_dout;
    logic                ioctl_wait;
    logic [CH_W-1:0]     ldr_ch;
    logic [ADDR_W-1:0]   ldr_addr;
    logic [8*BYTES-1:0]  ldr_wdat;
    logic [BYTES-1:0]    ldr_be;
    logic                ldr_wr;
    logic                ldr_ack;
    logic                ldr_aen;
    logic [NUM_CH-1:0]   ldr_done;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
        input  ioctl_wait, ldr_ch, ldr_addr, ldr_wdat, ldr_be, ldr_wr, ldr_aen, ldr_done
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
        output ioctl_wait, ldr_ch, ldr_addr, ldr_wdat, ldr_be, ldr_wr, ldr_aen, ldr_done
    );
endinterface

// File: rtl/ioctl_loader_bridge.sv
// rtl/ioctl_loader_bridge.sv - packs the hps_io byte stream into loader words with a req/ack FIFO
module ioctl_loader_bridge #(
    parameter int BYTES      = 2,
    parameter int ADDR_W     = 20,
    parameter int NUM_CH     = 2,
    parameter int CH_BASE    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    ioctl_loader_bridge_if.slave bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SHIFT  = $clog2(BYTES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [CH_W-1:0]    ch;
        logic [ADDR_W-1:0]  addr;
        logic [8*BYTES-1:0] data;
        logic [BYTES-1:0]   be;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    logic              dl_q, ack_q, valid_q, flush_pend, flush_pend_d, wait_q, wait_d;
    logic [CH_W-1:0]   ch_q, flush_ch;
    logic [NUM_CH-1:0] done_q;
    entry_t            part_q, part_d, e0, e1, out_q;
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp, rp;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [1:0]        n_push;
    state_t            state_q, state_d;
    logic              pop, load_out, flush_go;

    logic dl_rise, dl_fall, ch_live, accept, idx_ok;
    logic [8:0]        ch_diff;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] waddr;
    logic              unused_addr_bits;

    assign dl_rise = bus.ioctl_download & ~dl_q;
    assign dl_fall = ~bus.ioctl_download & dl_q;
    assign ch_diff = {1'b0, bus.ioctl_index} - 9'(CH_BASE);
    assign idx_ok  = ~ch_diff[8] && (ch_diff < 9'(NUM_CH));
    assign ch_live = valid_q & ~done_q[ch_q];
    // dl_q (not the live level) gates bytes so the final byte on the falling edge still lands
    assign accept  = bus.ioctl_wr & dl_q & ch_live;
    assign lane    = (BYTES > 1) ? bus.ioctl_addr[LANE_W-1:0] : '0;
    assign waddr   = ADDR_W'(bus.ioctl_addr >> SHIFT);
    assign unused_addr_bits = ^bus.ioctl_addr;

    // Up to two pushes per byte: a discontinuity flush of the old word, then a full or final word
    always_comb begin
        part_d = part_q;
        e0     = '0;
        e1     = '0;
        n_push = 2'd0;
        if (accept) begin
            if (part_q.be != '0 && waddr != part_q.addr) begin
                e0     = part_q;
                n_push = 2'd1;
                part_d = '0;
            end
            part_d.ch                = ch_q;
            part_d.addr              = waddr;
            part_d.be[lane]          = 1'b1;
            part_d.data[8*lane +: 8] = bus.ioctl_dout;
            if (int'(lane) == BYTES - 1) begin
                if (n_push == 2'd0) e0 = part_d; else e1 = part_d;
                n_push = n_push + 2'd1;
                part_d = '0;
            end
        end
        if (dl_fall && part_d.be != '0) begin
            if (n_push == 2'd0) e0 = part_d; else e1 = part_d;
            n_push = n_push + 2'd1;
            part_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load_out = 1'b0;
        case (state_q)
            S_IDLE: if (cnt != '0) begin
                state_d  = S_REQ;
                load_out = 1'b1;
            end
            S_REQ: if (bus.ldr_ack && !ack_q) begin
                pop     = 1'b1;
                state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d        = cnt + CNT_W'(n_push) - CNT_W'(pop);
    assign flush_go     = flush_pend && (cnt == '0) && (state_q == S_IDLE);
    assign flush_pend_d = (flush_pend & ~flush_go) | (dl_fall & ch_live);
    // The threshold leaves one slot spare for a byte that forces two pushes
    assign wait_d       = (cnt_d >= CNT_W'(FIFO_DEPTH - 1)) | (flush_pend_d & bus.ioctl_download);

    always_ff @(posedge clk_sys) begin
        if (n_push != 2'd0) mem[wp] <= e0;
        if (n_push == 2'd2) mem[wp + PTR_W'(1)] <= e1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            dl_q       <= 1'b0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            ch_q       <= '0;
            flush_pend <= 1'b0;
            flush_ch   <= '0;
            done_q     <= '0;
            wait_q     <= 1'b0;
            part_q     <= '0;
            out_q      <= '0;
            state_q    <= S_IDLE;
        end else begin
            wp         <= wp + PTR_W'(n_push);
            if (pop) rp <= rp + PTR_W'(1);
            cnt        <= cnt_d;
            dl_q       <= bus.ioctl_download;
            ack_q      <= bus.ldr_ack;
            part_q     <= part_d;
            state_q    <= state_d;
            wait_q     <= wait_d;
            flush_pend <= flush_pend_d;
            if (dl_rise) begin
                valid_q <= idx_ok;
                ch_q    <= CH_W'(ch_diff);
            end
            if (dl_fall && ch_live) flush_ch <= ch_q;
            if (flush_go) done_q[flush_ch] <= 1'b1;
            if (load_out) out_q <= mem[rp];
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.ldr_wr     = (state_q == S_REQ);
    assign bus.ldr_ch     = out_q.ch;
    assign bus.ldr_addr   = out_q.addr;
    assign bus.ldr_wdat   = out_q.data;
    assign bus.ldr_be     = out_q.be;
    assign bus.ldr_done   = done_q;
    assign bus.ldr_aen    = (bus.ioctl_download & ch_live) | flush_pend;
endmodule
